usb_disk_word_bridge: RTL
=========================

USB_DISK_WORD_BRIDGE -- requirements
Module: usb_disk_word_bridge

Interface
REQ-001 Parameter IDLE_FLUSH_CYCLES, default 64: cycles without mem_wen after which a partial write word is flushed.
REQ-002 clk  in  1  clock; 60 MHz.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 mem_addr  in  41  byte address from the disk controller.
REQ-005 mem_wen  in  1  byte write strobe, one cycle per byte.
REQ-006 mem_wdata  in  8  byte to write.
REQ-007 mem_rdata  out  8  byte at mem_addr.
REQ-008 m_req  out  1  backing-bus request.
REQ-009 m_we  out  1  1 = write, 0 = read.
REQ-010 m_addr  out  39  word address.
REQ-011 m_wdata  out  32  write word; byte n at bits [8n+7:8n].
REQ-012 m_be  out  4  write byte enables.
REQ-013 m_ack  in  1  single-cycle completion.
REQ-014 m_rdata  in  32  read word, valid with m_ack.
REQ-015 busy  out  1  m_req | wpend | fvalid.
REQ-016 err_ovf  out  1  sticky write-overflow flag.

Function
REQ-017 Read cache is one word: cvalid, ctag[38:0], cdata[31:0]; mem_rdata = cdata byte mem_addr[1:0], combinational.
REQ-018 Miss: !cvalid or mem_addr[40:2] != ctag.
  - Fill issued in IDLE on a miss only when mem_wen=0, wpend=0 and fvalid=0.
REQ-019 Fill: m_addr = mem_addr[40:2].
  - On m_ack: cdata <= m_rdata, with any wbuf bytes to that word overlaid per wbe.
  - ctag <= m_addr; cvalid <= 1.
REQ-020 Write buffer: wpend, waddr[38:0], wdata[31:0], wbe[3:0]. On mem_wen:
  - If wpend=0 or mem_addr[40:2] == waddr: merge byte into lane mem_addr[1:0] and set that wbe bit.
  - Else: move the buffer to the flush register, then start a fresh buffer with the byte.
REQ-021 When wbe becomes 4'hF, the buffer moves to the flush register on the next cycle and wpend clears.
REQ-022 An idle counter resets on every mem_wen. At IDLE_FLUSH_CYCLES cycles with wpend=1, the buffer moves to the flush register.
REQ-023 Flush register: fvalid, faddr, fdata, fbe.
  - A move while fvalid=1 and the flush is not completing that cycle sets err_ovf.
  - On overflow the old flush contents are overwritten.
REQ-024 Coherency: any mem_wen whose word equals ctag with cvalid=1 updates that cdata byte in the same cycle.
REQ-025 FSM states IDLE, WR, RD.
  - IDLE->WR when fvalid=1 (write has priority over a fill).
  - IDLE->RD on an issuable miss.
  - WR/RD->IDLE on m_ack.
REQ-026 m_req, m_we, m_addr, m_wdata and m_be are registered and held stable from request until the m_ack cycle.
  - m_req deasserts the cycle after m_ack.
  - Only one transaction is outstanding.
REQ-027 The WR m_ack clears fvalid, unless a new move arrives in the same cycle (REQ-023).
REQ-028 System constraint: m_ack latency SHALL be ≤ 20 cycles so mem_rdata settles before the USB core samples the next byte.
REQ-029 m_ack outside WR/RD is ignored.

Reset
REQ-030 rstn=0 clears cvalid, wpend, fvalid, the idle counter and err_ovf, and sets the FSM to IDLE.
REQ-031 rstn=0 drives m_req, m_we, m_addr, m_wdata, m_be, busy and mem_rdata to 0.
REQ-032 Reset mid-transaction abandons it; a late m_ack after reset is ignored.

Verification
REQ-033 Read fill: mem_addr=0x1003, m_ack after 5 cycles with m_rdata=0xAABBCCDD.
  - Expect m_req with m_we=0, m_addr=0x400.
  - Then mem_rdata=0xAA; mem_addr=0x1000 gives 0xDD with no new request.
REQ-034 Full word: write 0x11,0x22,0x33,0x44 to addresses 0x2000–0x2003.
  - Expect exactly one write with m_addr=0x800, m_wdata=0x44332211, m_be=4'hF.
REQ-035 Partial word: write 0x55 to 0x3001, then idle.
  - Expect a write after 64 cycles with m_be=4'b0010, m_wdata[15:8]=0x55.
REQ-036 Word change: write 0x2004 then 0x2008 while m_ack is withheld.
  - Expect two writes in order with m_addr 0x801 then 0x802.
  - A third word change before the first ack sets err_ovf=1.
REQ-037 Coherency: cache holds word 0x400; write 0x77 to 0x1001.
  - Expect mem_rdata at 0x1001 = 0x77 next cycle, with no read request.
REQ-038 Reset: rstn=0 during RD.
  - Expect m_req=0 immediately; a late m_ack leaves cvalid=0.

Source files
------------

// File: rtl/usb_disk_word_bridge.sv
// usb_disk_word_bridge
// Bridges the disk controller's byte-wide memory port onto a 32-bit word bus.
// Reads are served from a one-word cache that is filled on a miss. Writes are
// gathered in a one-word write buffer. The buffer is handed to a flush
// register when the word fills, when the byte address moves to another word,
// or after IDLE_FLUSH_CYCLES quiet cycles. The FSM drains the flush register
// with priority over cache fills, and keeps one bus transaction in flight.
//
// Ports:
//   clk, rstn          clock and asynchronous active-low reset
//   mem_addr/wen/wdata byte-side request (byte address, write strobe, data)
//   mem_rdata          byte at mem_addr, taken combinationally from the cache
//   m_req/we/addr/     word bus request, registered and held until m_ack
//   m_wdata/m_be
//   m_ack/m_rdata      single-cycle completion with read data
//   busy               transaction in flight or write data not yet flushed
//   err_ovf            sticky: flush register overwritten before it drained
module usb_disk_word_bridge #(
    parameter int IDLE_FLUSH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [40:0] mem_addr,
    input  logic        mem_wen,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [38:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err_ovf
);

    localparam int CW = $clog2(IDLE_FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t      state, state_nxt;
    logic        cvalid, wpend, fvalid;
    logic [38:0] ctag, waddr, faddr;
    logic [31:0] cdata, wdata, fdata;
    logic [3:0]  wbe, fbe;
    logic [CW-1:0] idle_cnt;

    logic [38:0] word;
    logic [1:0]  lane;
    logic        hit, issue_rd, wr_done, rd_done;
    logic        wen_new_word, full_move, idle_move, move;
    logic [31:0] merged_data, move_data, fill_data;
    logic [3:0]  merged_be, move_be;

    logic        req_nxt, we_nxt;
    logic [38:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic [3:0]  be_nxt;

    assign word      = mem_addr[40:2];
    assign lane      = mem_addr[1:0];
    assign hit       = cvalid && (word == ctag);
    assign issue_rd  = !hit && !mem_wen && !wpend && !fvalid;
    assign wr_done   = (state == WR) && m_ack;
    assign rd_done   = (state == RD) && m_ack;
    assign busy      = m_req | wpend | fvalid;
    assign mem_rdata = cdata[{lane, 3'b000} +: 8];

    // A byte to a different word evicts the buffer; a full word leaves one
    // cycle after it fills; a quiet buffer leaves after the idle timeout.
    assign wen_new_word = mem_wen && wpend && (word != waddr);
    assign full_move    = wpend && (wbe == 4'hF) && !wen_new_word;
    assign idle_move    = wpend && !mem_wen && (idle_cnt == CW'(IDLE_FLUSH_CYCLES - 1));
    assign move         = wen_new_word || full_move || idle_move;

    // The incoming byte merges into the current buffer, or into an empty one
    // when the buffer is idle or being evicted by a word change.
    always_comb begin
        merged_data = (wpend && !wen_new_word) ? wdata : 32'h0;
        merged_be   = (wpend && !wen_new_word) ? wbe : 4'h0;
        merged_data[{lane, 3'b000} +: 8] = mem_wdata;
        merged_be   = merged_be | (4'b0001 << lane);
        if (mem_wen && !wen_new_word) begin
            move_data = merged_data;
            move_be   = merged_be;
        end else begin
            move_data = wdata;
            move_be   = wbe;
        end
    end

    // Fill data is the bus word with any newer local bytes for that word laid
    // on top: flush register first, then the write buffer, then this cycle's byte.
    always_comb begin
        fill_data = m_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fvalid && (faddr == m_addr) && fbe[i])
                fill_data[8*i +: 8] = fdata[8*i +: 8];
            if (wpend && (waddr == m_addr) && wbe[i])
                fill_data[8*i +: 8] = wdata[8*i +: 8];
            if (mem_wen && (word == m_addr) && (lane == 2'(i)))
                fill_data[8*i +: 8] = mem_wdata;
        end
    end

    // Write buffer and idle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wpend    <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            wbe      <= '0;
            idle_cnt <= '0;
        end else begin
            if (wen_new_word || (mem_wen && !move)) begin
                wpend <= 1'b1;
                waddr <= word;
                wdata <= merged_data;
                wbe   <= merged_be;
            end else if (move) begin
                wpend <= 1'b0;
            end
            if (mem_wen || move)
                idle_cnt <= '0;
            else if (wpend)
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // Flush register; a move that lands while an undrained flush is still
    // held loses the old contents and raises the sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fvalid  <= 1'b0;
            faddr   <= '0;
            fdata   <= '0;
            fbe     <= '0;
            err_ovf <= 1'b0;
        end else if (move) begin
            fvalid <= 1'b1;
            faddr  <= waddr;
            fdata  <= move_data;
            fbe    <= move_be;
            if (fvalid && !wr_done)
                err_ovf <= 1'b1;
        end else if (wr_done) begin
            fvalid <= 1'b0;
        end
    end

    // Read cache: loaded on fill completion, kept coherent with byte writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cvalid <= 1'b0;
            ctag   <= '0;
            cdata  <= '0;
        end else if (rd_done) begin
            cvalid <= 1'b1;
            ctag   <= m_addr;
            cdata  <= fill_data;
        end else if (mem_wen && hit) begin
            cdata[{lane, 3'b000} +: 8] <= mem_wdata;
        end
    end

    // State register together with the registered bus request fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
        end else begin
            state   <= state_nxt;
            m_req   <= req_nxt;
            m_we    <= we_nxt;
            m_addr  <= addr_nxt;
            m_wdata <= wdata_nxt;
            m_be    <= be_nxt;
        end
    end

    // Next state: pending flushes win over fills; acks outside WR/RD are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fvalid)
                    state_nxt = WR;
                else if (issue_rd)
                    state_nxt = RD;
            end
            WR, RD: begin
                if (m_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the bus request: loaded when leaving IDLE, held until
    // the ack cycle, with m_req dropping on the edge that takes the ack.
    always_comb begin
        req_nxt   = m_req;
        we_nxt    = m_we;
        addr_nxt  = m_addr;
        wdata_nxt = m_wdata;
        be_nxt    = m_be;
        case (state)
            IDLE: begin
                if (fvalid) begin
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = faddr;
                    wdata_nxt = fdata;
                    be_nxt    = fbe;
                end else if (issue_rd) begin
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = word;
                    wdata_nxt = 32'h0;
                    be_nxt    = 4'h0;
                end else begin
                    req_nxt   = 1'b0;
                end
            end
            WR, RD: begin
                if (m_ack)
                    req_nxt = 1'b0;
            end
            default: req_nxt = 1'b0;
        endcase
    end

endmodule
